multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Moore-style main control FSM for the multicycle RV32I core. It sequences the shared datapath (PC, IR, single ALU, unified memory port, register file) through fetch/decode/execute/writeback. It generates all datapath selects and write enables, including ImmSrc for the immediate extender. It holds on a memory ready handshake and flags illegal instructions.

Parameters:
ILLEGAL_HALT, 1, 1: unsupported instruction parks in ILLEGAL until reset; 0: treated as NOP (back to FETCH)
STATE_W, 4, state register width

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
op  in  7  IR[6:0], stable from DECODE onward
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
zero  in  1  ALU zero flag (combinational, current cycle)
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  PC load enable
AdrSrc  out  1  0=PC, 1=ALUOut as memory address
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR and OldPC load enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero
ALUSrcB  out  2  00=rs2, 01=ImmExt, 10=constant 4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
instr_done  out  1  1-cycle pulse on final cycle of each retired instruction
illegal_instr  out  1  high while in ILLEGAL

Behaviour:
- Reset: async on reset_n low; state=FETCH. While reset_n=0, PCWrite/IRWrite/RegWrite/MemWrite/instr_done/illegal_instr are forced to 0. First fetch begins on the first rising edge after release.
- Outputs are decoded from state only. Exceptions: ImmSrc/ALUControl also depend on op/funct3/funct7b5; BRANCH PCWrite depends on zero; mem-wait strobes depend on mem_ready.
- ImmSrc is a function of op in every state. op 3/19/103→000; 35→001; 99→010; 111→011; 23/55→100; other→000.
- ALUOp is internal: 00 add, 01 sub, 10 funct-decoded. funct3 000: sub if op[5]&funct7b5, else add. 010→slt; 100→xor; 110→or; 111→and.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stay in FETCH while mem_ready=0; →DECODE when 1.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jal target into ALUOut). Next state by op:
  - 3/35→MEMADR
  - 51→EXECUTER
  - 19→EXECUTEI
  - 99→BRANCH
  - 111→JAL
  - 103→JALR
  - 55→LUI
  - 23→AUIPC
- DECODE illegal cases go to ILLEGAL (or FETCH with instr_done if ILLEGAL_HALT=0):
  - unlisted op
  - op 51/19 with funct3 ∈ {001,011,101}
  - op 99 with funct3 ∉ {000,001}
- MEMADR: ALUSrcA=10, ALUSrcB=01, add; op 3→MEMREAD, op 35→MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00; hold until mem_ready=1, then →MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1 →FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held every cycle until mem_ready=1; that cycle instr_done=1 →FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 →ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 →ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1 →FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = zero XOR funct3[0] (beq/bne). instr_done=1 →FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 →ALUWB (rd←OldPC+4).
- JALR: ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, PCWrite=1 →JALRWB.
- JALRWB: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1, instr_done=1 →FETCH.
- LUI: ALUSrcA=11, ALUSrcB=01, add →ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, add →ALUWB.
- ILLEGAL: all enables 0, illegal_instr=1, self-loop until reset.
- Unreachable state encodings →FETCH next cycle, with all enables 0.
- Reset mid-wait (e.g. MEMWRITE with mem_ready=0) drops MemWrite immediately (async); no partial writeback.
- Latencies assume mem_ready=1 on the first opportunity:
  - R/I/lui/auipc: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - jal: 4 cycles
  - jalr: 4 cycles

Decomposition:
- Shared package holds: state encodings, opcode constants (3,19,23,35,51,55,99,103,111), ImmSrc codes, ALUControl codes, ALUOp codes, ResultSrc/ALUSrcA/ALUSrcB select codes.
- One sub-module, alu_decoder (ALUOp, funct3, funct7b5, op[5] → ALUControl), instantiated once.
- ImmSrc decode stays inline.

Test Plan:
- Reset then add (op=51, f3=000, f7b5=0), mem_ready=1: state path FETCH,DECODE,EXECUTER,ALUWB; RegWrite=1 only in cycle 4; instr_done pulse in cycle 4.
- lw (op=3) with mem_ready low 2 cycles in FETCH and 3 in MEMREAD: IRWrite fires once, on the 3rd FETCH cycle; RegWrite with ResultSrc=01 after MEMREAD completes; total 10 cycles.
- beq zero=1 → PCWrite=1 in BRANCH. bne (f3=001) zero=1 → PCWrite=0. ImmSrc=010 in both.
- jalr (op=103): PCWrite with ResultSrc=10 in JALR, then RegWrite with ALUSrcA=01, ALUSrcB=10 in JALRWB; ImmSrc=000.
- op=0x7F: illegal_instr=1 from the cycle after DECODE and held. With ILLEGAL_HALT=0: instr_done in DECODE, then FETCH.
- sw with mem_ready=0 held, reset_n pulled low mid-MEMWRITE: MemWrite drops combinationally; after release state=FETCH, no RegWrite/MemWrite.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I main controller: states, opcodes and datapath select codes.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_JALRWB   = 4'd12,
      S_LUI      = 4'd13,
      S_AUIPC    = 4'd14,
      S_ILLEGAL  = 4'd15
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'd3;
   localparam logic [6:0] OP_OPIMM  = 7'd19;
   localparam logic [6:0] OP_AUIPC  = 7'd23;
   localparam logic [6:0] OP_STORE  = 7'd35;
   localparam logic [6:0] OP_OP     = 7'd51;
   localparam logic [6:0] OP_LUI    = 7'd55;
   localparam logic [6:0] OP_BRANCH = 7'd99;
   localparam logic [6:0] OP_JALR   = 7'd103;
   localparam logic [6:0] OP_JAL    = 7'd111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode: ALUOp plus funct fields to ALUControl.
module multicycle_controller_alu_decoder
   import multicycle_controller_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       op5_i,
   output logic [2:0] alu_control_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_SUB:   alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control_o = ALU_SLT;
               3'b100:  alu_control_o = ALU_XOR;
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default:     alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/writeback
// over the shared datapath, stalls on mem_ready and traps unsupported instructions.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 when memory ready
// DECODE   | ALUOut <= OldPC+imm (branch/jal target), choose path
// MEMADR   | ALUOut <= rs1+imm (load/store address)
// MEMREAD  | load from ALUOut, wait for mem_ready
// MEMWB    | rd <= load data
// MEMWRITE | store to ALUOut, wait for mem_ready
// EXECUTER | ALUOut <= rs1 op rs2
// EXECUTEI | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rs1-rs2, PC <= ALUOut if taken
// JAL      | PC <= target, ALUOut <= OldPC+4
// JALR     | PC <= rs1+imm
// JALRWB   | rd <= OldPC+4
// LUI      | ALUOut <= 0+imm
// AUIPC    | ALUOut <= OldPC+imm
// ILLEGAL  | unsupported instruction, parked until reset
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int ILLEGAL_HALT = 1,
   parameter int STATE_W      = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [2:0] ImmSrc,
   output logic       instr_done,
   output logic       illegal_instr
);

   logic [STATE_W-1:0] state_q, state_d;
   state_t             st, nxt;
   logic [1:0]         alu_op;
   logic               pcw_c, mw_c, irw_c, rw_c, done_c, ill_c;
   logic               dec_ill, f3_alu_bad;

   assign st      = state_t'(state_q);
   assign state_d = STATE_W'(nxt);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= STATE_W'(S_FETCH);
      else          state_q <= state_d;
   end

   assign f3_alu_bad = (funct3 == 3'b001) || (funct3 == 3'b011) || (funct3 == 3'b101);

   always_comb begin
      nxt       = S_FETCH;
      pcw_c     = 1'b0;
      mw_c      = 1'b0;
      irw_c     = 1'b0;
      rw_c      = 1'b0;
      done_c    = 1'b0;
      ill_c     = 1'b0;
      dec_ill   = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      alu_op    = ALUOP_ADD;
      case (st)
         S_FETCH: begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            pcw_c     = mem_ready;
            irw_c     = mem_ready;
            nxt       = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: nxt = S_MEMADR;
               OP_OP:     begin nxt = S_EXECUTER; dec_ill = f3_alu_bad; end
               OP_OPIMM:  begin nxt = S_EXECUTEI; dec_ill = f3_alu_bad; end
               OP_BRANCH: begin nxt = S_BRANCH;   dec_ill = (funct3[2:1] != 2'b00); end
               OP_JAL:    nxt = S_JAL;
               OP_JALR:   nxt = S_JALR;
               OP_LUI:    nxt = S_LUI;
               OP_AUIPC:  nxt = S_AUIPC;
               default:   dec_ill = 1'b1;
            endcase
            // Non-halting builds retire an illegal instruction here as a NOP.
            if (dec_ill) begin
               if (ILLEGAL_HALT != 0) begin
                  nxt = S_ILLEGAL;
               end else begin
                  nxt    = S_FETCH;
                  done_c = 1'b1;
               end
            end
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            if (op == OP_LOAD)       nxt = S_MEMREAD;
            else if (op == OP_STORE) nxt = S_MEMWRITE;
            else                     nxt = S_FETCH;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            nxt    = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            rw_c      = 1'b1;
            done_c    = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            mw_c   = 1'b1;
            done_c = mem_ready;
            nxt    = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_FUNCT;
            nxt     = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
            nxt     = S_ALUWB;
         end
         S_ALUWB: begin
            rw_c   = 1'b1;
            done_c = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_SUB;
            pcw_c   = zero ^ funct3[0];
            done_c  = 1'b1;
         end
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            pcw_c   = 1'b1;
            nxt     = S_ALUWB;
         end
         S_JALR: begin
            ALUSrcA   = SRCA_RS1;
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURESULT;
            pcw_c     = 1'b1;
            nxt       = S_JALRWB;
         end
         S_JALRWB: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            rw_c      = 1'b1;
            done_c    = 1'b1;
         end
         S_LUI: begin
            ALUSrcA = SRCA_ZERO;
            ALUSrcB = SRCB_IMM;
            nxt     = S_ALUWB;
         end
         S_AUIPC: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            nxt     = S_ALUWB;
         end
         S_ILLEGAL: begin
            ill_c = 1'b1;
            nxt   = S_ILLEGAL;
         end
         default: nxt = S_FETCH;
      endcase
   end

   always_comb begin
      case (op)
         OP_LOAD, OP_OPIMM, OP_JALR: ImmSrc = IMM_I;
         OP_STORE:                   ImmSrc = IMM_S;
         OP_BRANCH:                  ImmSrc = IMM_B;
         OP_JAL:                     ImmSrc = IMM_J;
         OP_AUIPC, OP_LUI:           ImmSrc = IMM_U;
         default:                    ImmSrc = IMM_I;
      endcase
   end

   multicycle_controller_alu_decoder u_alu_decoder (
      .alu_op_i      (alu_op),
      .funct3_i      (funct3),
      .funct7b5_i    (funct7b5),
      .op5_i         (op[5]),
      .alu_control_o (ALUControl)
   );

   // Strobes are gated by reset_n so a write in flight is dropped the moment reset asserts.
   assign PCWrite       = reset_n & pcw_c;
   assign MemWrite      = reset_n & mw_c;
   assign IRWrite       = reset_n & irw_c;
   assign RegWrite      = reset_n & rw_c;
   assign instr_done    = reset_n & done_c;
   assign illegal_instr = reset_n & ill_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors are queued with stimulus.
module tb_multicycle_controller;

   logic       clk, reset_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, zero, mem_ready;

   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_instr;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ALUControl, ImmSrc;

   logic       nh_PCWrite, nh_AdrSrc, nh_MemWrite, nh_IRWrite, nh_RegWrite, nh_done, nh_ill;
   logic [1:0] nh_ResultSrc, nh_ALUSrcA, nh_ALUSrcB;
   logic [2:0] nh_ALUControl, nh_ImmSrc;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic        mr;
      logic        z;
      logic [18:0] e;
   } stim_t;

   stim_t      sb_q[$];
   logic [6:0] c_op;
   logic [2:0] c_f3;
   logic       c_f7;
   logic [18:0] outs;

   assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUControl, ImmSrc, instr_done, illegal_instr};

   multicycle_controller #(.ILLEGAL_HALT(1), .STATE_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
      .instr_done(instr_done), .illegal_instr(illegal_instr)
   );

   multicycle_controller #(.ILLEGAL_HALT(0), .STATE_W(4)) dut_nh (
      .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .PCWrite(nh_PCWrite), .AdrSrc(nh_AdrSrc),
      .MemWrite(nh_MemWrite), .IRWrite(nh_IRWrite), .RegWrite(nh_RegWrite),
      .ResultSrc(nh_ResultSrc), .ALUSrcA(nh_ALUSrcA), .ALUSrcB(nh_ALUSrcB),
      .ALUControl(nh_ALUControl), .ImmSrc(nh_ImmSrc), .instr_done(nh_done),
      .illegal_instr(nh_ill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [18:0] ev(input logic pcw, adr, mw, irw, rw,
                                      input logic [1:0] rs, sa, sb,
                                      input logic [2:0] ac, imm,
                                      input logic done, ill);
      return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, imm, done, ill};
   endfunction

   function automatic logic [18:0] e_fetch(input logic mr, input logic [2:0] imm);
      return ev(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
   endfunction

   function automatic logic [18:0] e_decode(input logic [2:0] imm);
      return ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0);
   endfunction

   function automatic logic [18:0] e_aluwb(input logic [2:0] imm);
      return ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1, 0);
   endfunction

   task automatic push(input logic mr, input logic z, input logic [18:0] e);
      stim_t s;
      s.op = c_op; s.f3 = c_f3; s.f7 = c_f7; s.mr = mr; s.z = z; s.e = e;
      sb_q.push_back(s);
   endtask

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      c_op = o; c_f3 = f3; c_f7 = f7;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; op = 7'd51; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      checks++;
      if (outs !== ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0)) begin
         errors++;
         $display("FAIL reset_outputs: got %b, expected FETCH decode with strobes low", outs);
      end
      checks++;
      if ({nh_PCWrite, nh_IRWrite, nh_done, nh_ill} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_nohalt_strobes: got %b, expected 0000",
                  {nh_PCWrite, nh_IRWrite, nh_done, nh_ill});
      end
      mem_ready = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      stim_t s;
      int n = 0;
      set_instr(7'd51, 3'b000, 1'b0);
      push(1, 0, e_fetch(1, 3'b000)); push(1, 0, e_decode(3'b000));
      push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0));
      push(1, 0, e_aluwb(3'b000));
      set_instr(7'd51, 3'b000, 1'b1);
      push(1, 0, e_fetch(1, 3'b000)); push(1, 0, e_decode(3'b000));
      push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0, 0));
      push(1, 0, e_aluwb(3'b000));
      set_instr(7'd51, 3'b100, 1'b0);
      push(1, 0, e_fetch(1, 3'b000)); push(1, 0, e_decode(3'b000));
      push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b100, 3'b000, 0, 0));
      push(1, 0, e_aluwb(3'b000));
      set_instr(7'd51, 3'b111, 1'b0);
      push(1, 0, e_fetch(1, 3'b000)); push(1, 0, e_decode(3'b000));
      push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000, 0, 0));
      push(1, 0, e_aluwb(3'b000));
      set_instr(7'd51, 3'b010, 1'b0);
      push(1, 0, e_fetch(1, 3'b000)); push(1, 0, e_decode(3'b000));
      push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b101, 3'b000, 0, 0));
      push(1, 0, e_aluwb(3'b000));
      set_instr(7'd19, 3'b110, 1'b0);
      push(1, 0, e_fetch(1, 3'b000)); push(1, 0, e_decode(3'b000));
      push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b011, 3'b000, 0, 0));
      push(1, 0, e_aluwb(3'b000));
      set_instr(7'd19, 3'b000, 1'b1);
      push(1, 0, e_fetch(1, 3'b000)); push(1, 0, e_decode(3'b000));
      push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
      push(1, 0, e_aluwb(3'b000));
      set_instr(7'd55, 3'b000, 1'b0);
      push(1, 0, e_fetch(1, 3'b100)); push(1, 0, e_decode(3'b100));
      push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b000, 3'b100, 0, 0));
      push(1, 0, e_aluwb(3'b100));
      set_instr(7'd23, 3'b000, 1'b0);
      push(1, 0, e_fetch(1, 3'b100)); push(1, 0, e_decode(3'b100));
      push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b100, 0, 0));
      push(1, 0, e_aluwb(3'b100));
      set_instr(7'd111, 3'b000, 1'b0);
      push(1, 0, e_fetch(1, 3'b011)); push(1, 0, e_decode(3'b011));
      push(1, 0, ev(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 0, 0));
      push(1, 0, e_aluwb(3'b011));
      while (sb_q.size() > 0) begin
         s = sb_q.pop_front();
         @(negedge clk);
         op = s.op; funct3 = s.f3; funct7b5 = s.f7; mem_ready = s.mr; zero = s.z;
         #2;
         checks++;
         if (outs !== s.e) begin
            errors++;
            $display("FAIL b2b cyc%0d op=%0d: got %b, expected %b", n, s.op, outs, s.e);
         end
         n++;
      end
   endtask

   task automatic test_mem();
      stim_t s;
      int n = 0;
      set_instr(7'd3, 3'b010, 1'b0);
      push(0, 0, e_fetch(0, 3'b000)); push(0, 0, e_fetch(0, 3'b000));
      push(1, 0, e_fetch(1, 3'b000)); push(1, 0, e_decode(3'b000));
      push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
      for (int i = 0; i < 3; i++)
         push(0, 0, ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
      push(1, 0, ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
      push(1, 0, ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0));
      set_instr(7'd35, 3'b010, 1'b0);
      push(1, 0, e_fetch(1, 3'b001)); push(1, 0, e_decode(3'b001));
      push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0, 0));
      push(1, 0, ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 1, 0));
      while (sb_q.size() > 0) begin
         s = sb_q.pop_front();
         @(negedge clk);
         op = s.op; funct3 = s.f3; funct7b5 = s.f7; mem_ready = s.mr; zero = s.z;
         #2;
         checks++;
         if (outs !== s.e) begin
            errors++;
            $display("FAIL mem cyc%0d op=%0d: got %b, expected %b", n, s.op, outs, s.e);
         end
         n++;
      end
   endtask

   task automatic test_branch();
      stim_t s;
      int n = 0;
      set_instr(7'd99, 3'b000, 1'b0);
      push(1, 1, e_fetch(1, 3'b010)); push(1, 1, e_decode(3'b010));
      push(1, 1, ev(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 1, 0));
      push(1, 0, e_fetch(1, 3'b010)); push(1, 0, e_decode(3'b010));
      push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 1, 0));
      set_instr(7'd99, 3'b001, 1'b0);
      push(1, 1, e_fetch(1, 3'b010)); push(1, 1, e_decode(3'b010));
      push(1, 1, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 1, 0));
      push(1, 0, e_fetch(1, 3'b010)); push(1, 0, e_decode(3'b010));
      push(1, 0, ev(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 1, 0));
      set_instr(7'd103, 3'b000, 1'b0);
      push(1, 0, e_fetch(1, 3'b000)); push(1, 0, e_decode(3'b000));
      push(1, 0, ev(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
      push(1, 0, ev(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b000, 3'b000, 1, 0));
      while (sb_q.size() > 0) begin
         s = sb_q.pop_front();
         @(negedge clk);
         op = s.op; funct3 = s.f3; funct7b5 = s.f7; mem_ready = s.mr; zero = s.z;
         #2;
         checks++;
         if (outs !== s.e) begin
            errors++;
            $display("FAIL branch_jalr cyc%0d op=%0d: got %b, expected %b", n, s.op, outs, s.e);
         end
         n++;
      end
   endtask

   task automatic test_sw_reset();
      stim_t s;
      int n = 0;
      set_instr(7'd35, 3'b010, 1'b0);
      push(1, 0, e_fetch(1, 3'b001)); push(1, 0, e_decode(3'b001));
      push(0, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0, 0));
      push(0, 0, ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0, 0));
      push(0, 0, ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0, 0));
      while (sb_q.size() > 0) begin
         s = sb_q.pop_front();
         @(negedge clk);
         op = s.op; funct3 = s.f3; funct7b5 = s.f7; mem_ready = s.mr; zero = s.z;
         #2;
         checks++;
         if (outs !== s.e) begin
            errors++;
            $display("FAIL sw_wait cyc%0d: got %b, expected %b", n, outs, s.e);
         end
         n++;
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (MemWrite !== 1'b0) begin
         errors++;
         $display("FAIL sw_reset_memwrite: got %b, expected 0", MemWrite);
      end
      checks++;
      if (outs !== ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b001, 0, 0)) begin
         errors++;
         $display("FAIL sw_reset_state: got %b, expected FETCH outputs", outs);
      end
      @(negedge clk);
      reset_n = 1'b1;
      push(0, 0, e_fetch(0, 3'b001)); push(1, 0, e_fetch(1, 3'b001));
      push(1, 0, e_decode(3'b001));
      push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0, 0));
      push(1, 0, ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 1, 0));
      while (sb_q.size() > 0) begin
         s = sb_q.pop_front();
         @(negedge clk);
         op = s.op; funct3 = s.f3; funct7b5 = s.f7; mem_ready = s.mr; zero = s.z;
         #2;
         checks++;
         if (outs !== s.e) begin
            errors++;
            $display("FAIL sw_after_reset cyc%0d: got %b, expected %b", n, outs, s.e);
         end
         n++;
      end
   endtask

   task automatic test_illegal();
      stim_t s;
      int n = 0;
      set_instr(7'h7F, 3'b000, 1'b0);
      push(1, 0, e_fetch(1, 3'b000)); push(1, 0, e_decode(3'b000));
      for (int i = 0; i < 3; i++)
         push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 1));
      while (sb_q.size() > 0) begin
         s = sb_q.pop_front();
         @(negedge clk);
         op = s.op; funct3 = s.f3; funct7b5 = s.f7; mem_ready = s.mr; zero = s.z;
         #2;
         checks++;
         if (outs !== s.e) begin
            errors++;
            $display("FAIL illegal_halt cyc%0d: got %b, expected %b", n, outs, s.e);
         end
         if (n == 1) begin
            checks++;
            if (nh_done !== 1'b1) begin
               errors++;
               $display("FAIL illegal_nohalt_done: got %b, expected 1", nh_done);
            end
         end
         if (n == 2) begin
            checks++;
            if ({nh_ill, nh_IRWrite} !== 2'b01) begin
               errors++;
               $display("FAIL illegal_nohalt_fetch: got ill/irw=%b, expected 01", {nh_ill, nh_IRWrite});
            end
         end
         n++;
      end
      for (int k = 0; k < 2; k++) begin
         reset_n = 1'b0;
         #1;
         checks++;
         if (illegal_instr !== 1'b0) begin
            errors++;
            $display("FAIL illegal_reset_clear: got %b, expected 0", illegal_instr);
         end
         mem_ready = 1'b0;
         @(negedge clk);
         reset_n = 1'b1;
         if (k == 0) begin
            set_instr(7'd51, 3'b001, 1'b0);
            push(1, 0, e_fetch(1, 3'b000)); push(1, 0, e_decode(3'b000));
            push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 1));
         end else begin
            set_instr(7'd99, 3'b100, 1'b0);
            push(1, 0, e_fetch(1, 3'b010)); push(1, 0, e_decode(3'b010));
            push(1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b010, 0, 1));
         end
         n = 0;
         while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            @(negedge clk);
            op = s.op; funct3 = s.f3; funct7b5 = s.f7; mem_ready = s.mr; zero = s.z;
            #2;
            checks++;
            if (outs !== s.e) begin
               errors++;
               $display("FAIL illegal_funct3 op=%0d f3=%b cyc%0d: got %b, expected %b",
                        s.op, s.f3, n, outs, s.e);
            end
            n++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_mem();
      test_branch();
      test_sw_reset();
      test_illegal();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
